// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// FSM state encoding, decoder blank code and nibble selection.
package seg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SETUP = 2'd2;
  localparam logic [1:0] ST_SHOW  = 2'd3;

  // The external decoder renders this code as all segments off.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int NUM_DIGITS = 4;

  function automatic logic [3:0] nibble_sel(input logic [15:0] value, input logic [1:0] idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero blanking: replaces zero nibbles above the first non-zero
// digit with the blank code. Digit 0 always passes through.
module seg_lzb_mask
  import seg_pkg::*;
(
  input  logic [15:0] i_value,
  input  logic        i_lzb,
  output logic [15:0] o_value
);

  logic [3:0] w_blank;

  assign w_blank[3] = i_lzb && (i_value[15:12] == 4'h0);
  assign w_blank[0] = 1'b0;

  // A digit blanks only when it is zero and everything above it blanked.
  generate
    for (genvar gi = 2; gi >= 1; gi--) begin : g_chain
      assign w_blank[gi] = w_blank[gi+1] && (i_value[gi*4 +: 4] == 4'h0);
    end
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_out
      assign o_value[gi*4 +: 4] = w_blank[gi] ? BLANK_CODE : i_value[gi*4 +: 4];
    end
  endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner: dead time, one setup cycle to
// preload the decoder nibble, then a lit dwell per digit.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LZB,
  input  logic        LOAD,
  input  logic [15:0] VALUE,
  output logic [3:0]  DIG_D,
  output logic [3:0]  AN,
  output logic        FRAME_DONE
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_digit;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [DEAD_W-1:0]  r_dead_cnt;
  logic [15:0]        r_pending;
  logic [15:0]        r_active;
  logic [3:0]         r_dig_d;
  logic [3:0]         r_an;
  logic               r_frame_done;

  logic [1:0]         w_state_next;
  logic [1:0]         w_digit_next;
  logic [DWELL_W-1:0] w_dwell_next;
  logic [DEAD_W-1:0]  w_dead_next;
  logic               w_frame_end;
  logic               w_copy;
  logic [15:0]        w_src;
  logic [15:0]        w_masked;
  logic [3:0]         w_nibble;

  always_comb begin
    w_state_next = r_state;
    w_digit_next = r_digit;
    w_dwell_next = r_dwell_cnt;
    w_dead_next  = r_dead_cnt;
    w_frame_end  = 1'b0;
    if (!EN) begin
      w_state_next = ST_IDLE;
      w_digit_next = 2'd0;
      w_dwell_next = '0;
      w_dead_next  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_BLANK;
          w_dead_next  = '0;
        end
        ST_BLANK: begin
          if (r_dead_cnt == DEAD_LAST) begin
            w_state_next = ST_SETUP;
            w_dead_next  = '0;
          end else begin
            w_dead_next = r_dead_cnt + 1'b1;
          end
        end
        ST_SETUP: begin
          w_state_next = ST_SHOW;
          w_dwell_next = '0;
        end
        default: begin
          if (r_dwell_cnt == DWELL_LAST) begin
            w_state_next = ST_BLANK;
            w_dwell_next = '0;
            w_digit_next = r_digit + 2'd1;
            w_frame_end  = (r_digit == 2'd3);
          end else begin
            w_dwell_next = r_dwell_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // The frame value transfers as digit 0 enters SETUP; that digit's nibble
  // is taken straight from pending so the whole frame stays consistent.
  assign w_copy = (w_state_next == ST_SETUP) && (w_digit_next == 2'd0);
  assign w_src  = w_copy ? r_pending : r_active;

  seg_lzb_mask u_lzb_mask (
    .i_value (w_src),
    .i_lzb   (LZB),
    .o_value (w_masked)
  );

  assign w_nibble = nibble_sel(w_masked, w_digit_next);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_digit      <= 2'd0;
      r_dwell_cnt  <= '0;
      r_dead_cnt   <= '0;
      r_pending    <= 16'h0000;
      r_active     <= 16'h0000;
      r_dig_d      <= BLANK_CODE;
      r_an         <= 4'b0000;
      r_frame_done <= 1'b0;
    end else begin
      if (LOAD) begin
        r_pending <= VALUE;
      end
      if (w_copy) begin
        r_active <= r_pending;
      end
      r_state      <= w_state_next;
      r_digit      <= w_digit_next;
      r_dwell_cnt  <= w_dwell_next;
      r_dead_cnt   <= w_dead_next;
      r_frame_done <= w_frame_end;
      r_an         <= (w_state_next == ST_SHOW) ? (4'b0001 << w_digit_next) : 4'b0000;
      // DIG_D settles during SETUP, a cycle before the anode turns on.
      if (w_state_next == ST_IDLE) begin
        r_dig_d <= BLANK_CODE;
      end else if (w_state_next == ST_SETUP) begin
        r_dig_d <= w_nibble;
      end
    end
  end

  assign DIG_D      = r_dig_d;
  assign AN         = r_an;
  assign FRAME_DONE = r_frame_done;

endmodule
